multi_debouncer: RTL



---
 rtl/multi_debouncer_pkg.sv | 30 +++
 rtl/debounce_channel.sv | 145 ++++++++++++++
 rtl/multi_debouncer.sv | 62 ++++++
 3 files changed

// File: rtl/multi_debouncer_pkg.sv
// Shared types and helpers for the multi-channel button/sensor debouncer.
//
// Contents:
//   db_state_t        - per-channel debounce FSM state (2 bits)
//   calc_count_value  - stable-time length in clk cycles (CLK_FREQUENCY / DEBOUNCE_HZ)
//   cnt_width         - bits needed to hold 0..max_val without wrapping
//   state_is_high     - decodes the debounced level from a channel state
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW          = 2'd0,
    CONFIRM_HIGH = 2'd1,
    HIGH         = 2'd2,
    CONFIRM_LOW  = 2'd3
  } db_state_t;

  function automatic int calc_count_value(input int clk_frequency, input int debounce_hz);
    return clk_frequency / debounce_hz;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // While confirming a release the debounced level is still high.
  function automatic logic state_is_high(input db_state_t s);
    return (s == HIGH) || (s == CONFIRM_LOW);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, restart-on-bounce confirm
// FSM with stable-time counter, registered press/release pulses and an
// optional long-hold detector.
//
// Optional feature macro: MULTI_DEBOUNCER_LONG_PRESS_EN
//   defined   - hold counter built, long_press pulses once per long hold
//   undefined - no hold counter, long_press tied 0
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   button        in   raw asynchronous input
//   press         out  one-cycle pulse, level 0->1
//   release_pulse out  one-cycle pulse, level 1->0 ('release' is a reserved word)
//   long_press    out  one-cycle pulse after a long continuous high level
//   state_dbg     out  current FSM state (level is decoded from it)
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int COUNT_VALUE       = 10,
  parameter int LONG_PRESS_CYCLES = 50
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      button,
  output logic      press,
  output logic      release_pulse,
  output logic      long_press,
  output db_state_t state_dbg
);

  localparam int              CW   = cnt_width(COUNT_VALUE);
  localparam logic [CW-1:0]   LAST = CW'(COUNT_VALUE - 1);

  logic          s1, s2;
  db_state_t     state, state_n;
  logic [CW-1:0] count, count_n;
  logic          press_n, release_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      state         <= LOW;
      count         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= button;
      s2            <= s1;
      state         <= state_n;
      count         <= count_n;
      press         <= press_n;
      release_pulse <= release_n;
    end
  end

  // The counter is cleared on every state entry; it only advances while
  // confirming, and a contrary s2 sample abandons the confirm immediately.
  always_comb begin
    state_n   = state;
    count_n   = count;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          state_n = CONFIRM_HIGH;
          count_n = '0;
        end
      end
      CONFIRM_HIGH: begin
        if (!s2) begin
          state_n = LOW;
          count_n = '0;
        end else if (count == LAST) begin
          state_n = HIGH;
          count_n = '0;
          press_n = 1'b1;
        end else begin
          count_n = count + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          state_n = CONFIRM_LOW;
          count_n = '0;
        end
      end
      CONFIRM_LOW: begin
        if (s2) begin
          state_n = HIGH;
          count_n = '0;
        end else if (count == LAST) begin
          state_n   = LOW;
          count_n   = '0;
          release_n = 1'b1;
        end else begin
          count_n = count + 1'b1;
        end
      end
      default: begin
        state_n = LOW;
        count_n = '0;
      end
    endcase
  end

  assign state_dbg = state;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
  localparam int            HW        = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);

  logic [HW-1:0] hold, hold_n;
  logic          long_q;

  // Any state other than HIGH zeroes the timer, so every entry to HIGH
  // (including a return from CONFIRM_LOW) starts a fresh hold.
  always_comb begin
    hold_n = '0;
    if (state == HIGH) begin
      hold_n = (hold == HOLD_MAX) ? hold : hold + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold   <= '0;
      long_q <= 1'b0;
    end else begin
      hold   <= hold_n;
      // hold passes through HOLD_FIRE only once before saturating.
      long_q <= (state == HIGH) && (hold == HOLD_FIRE);
    end
  end

  assign long_press = long_q;
`else
  // The hold length has no effect in this build.
  assign long_press = LONG_PRESS_CYCLES[0] & 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer for the parking-system front panel. One
// debounce_channel per input; this level packs the vectors and adds the
// registered any_press summary.
//
// Optional feature macro: MULTI_DEBOUNCER_LONG_PRESS_EN (long-hold pulses).
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   button        in   [CHANNELS] raw inputs, bit i = channel i
//   level         out  [CHANNELS] debounced level
//   press         out  [CHANNELS] one-cycle pulse on level 0->1
//   release_pulse out  [CHANNELS] one-cycle pulse on level 1->0
//   any_press     out  OR of press, one cycle later
//   long_press    out  [CHANNELS] long-hold pulse (0 without the feature)
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int CLK_FREQUENCY     = 40_000_000,
  parameter int DEBOUNCE_HZ       = 100,
  parameter int LONG_PRESS_CYCLES = 80_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                any_press,
  output logic [CHANNELS-1:0] long_press
);

  localparam int COUNT_VALUE = calc_count_value(CLK_FREQUENCY, DEBOUNCE_HZ);

  db_state_t ch_state [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .COUNT_VALUE      (COUNT_VALUE),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .button       (button[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .state_dbg    (ch_state[i])
    );
    assign level[i] = state_is_high(ch_state[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press;
    end
  end

endmodule
